// File: rtl/rv_lsu_pkg.sv
// rv_lsu_pkg: shared access-size codes, FSM state and width-decode helpers
// for the load/store unit.
`default_nettype none

package rv_lsu_pkg;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_REQ  = 2'd1,
    STATE_WAIT = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'd0,
    WIDTH_HALF = 2'd1,
    WIDTH_WORD = 2'd2
  } access_width_t;

  // Reserved codes fall through to a full-word access.
  function automatic access_width_t decode_width(input logic [2:0] size);
    case (size)
      SIZE_B, SIZE_BU: decode_width = WIDTH_BYTE;
      SIZE_H, SIZE_HU: decode_width = WIDTH_HALF;
      default:         decode_width = WIDTH_WORD;
    endcase
  endfunction

  function automatic logic is_signed_load(input logic [2:0] size);
    is_signed_load = (size == SIZE_B) || (size == SIZE_H);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_lsu_lane.sv
// rv_lsu_lane: combinational byte-lane steering -- byte enables, store
// replication and load lane extraction with sign/zero extension.
`default_nettype none

module rv_lsu_lane
  import rv_lsu_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  byte_enable,
  output logic [31:0] write_data,
  output logic [31:0] read_data
);

  access_width_t width;
  logic          sign_ext;
  logic [7:0]    load_byte;
  logic [15:0]   load_half;

  always_comb begin
    width    = decode_width(size);
    sign_ext = is_signed_load(size);

    case (offset)
      2'd0:    load_byte = load_word[7:0];
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      default: load_byte = load_word[31:24];
    endcase

    // Halfwords ignore offset[0]: the lower lane pair or the upper one.
    load_half = offset[1] ? load_word[31:16] : load_word[15:0];

    case (width)
      WIDTH_BYTE: begin
        byte_enable = 4'b0001 << offset;
        write_data  = {4{store_data[7:0]}};
        read_data   = {{24{sign_ext & load_byte[7]}}, load_byte};
      end
      WIDTH_HALF: begin
        byte_enable = offset[1] ? 4'b1100 : 4'b0011;
        write_data  = {2{store_data[15:0]}};
        read_data   = {{16{sign_ext & load_half[15]}}, load_half};
      end
      default: begin
        byte_enable = 4'b1111;
        write_data  = store_data;
        read_data   = load_word;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rv_lsu.sv
// rv_lsu: core-to-memory load/store unit with a three-state handshake FSM
// (IDLE / REQ awaiting begin / WAIT awaiting end).
`default_nettype none

module rv_lsu
  import rv_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] core_address,
  input  logic [31:0] core_write_data,
  input  logic        core_require,
  input  logic        core_write_enable,
  input  logic [2:0]  core_size,
  output logic [31:0] core_read_data,
  output logic        core_stall_signal,
  input  logic [31:0] memory_read_data,
  input  logic        memory_begin_signal,
  input  logic        memory_end_signal,
  output logic        memory_require,
  output logic        memory_write_enable,
  output logic [3:0]  memory_byte_enable_map,
  output logic [31:0] memory_address,
  output logic [31:0] memory_write_data
);

  lsu_state_t state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STATE_IDLE;
    end else if (!core_require) begin
      state <= STATE_IDLE;
    end else begin
      case (state)
        STATE_IDLE, STATE_REQ: begin
          // A same-cycle begin+end completes immediately.
          if (memory_end_signal)        state <= STATE_IDLE;
          else if (memory_begin_signal) state <= STATE_WAIT;
          else                          state <= STATE_REQ;
        end
        STATE_WAIT: begin
          if (memory_end_signal) state <= STATE_IDLE;
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

  always_comb begin
    memory_require      = core_require && (state != STATE_WAIT);
    memory_write_enable = core_write_enable && memory_require;
    core_stall_signal   = core_require && !memory_end_signal;
    memory_address      = {core_address[31:2], 2'b00};
  end

  rv_lsu_lane u_lane (
    .offset      (core_address[1:0]),
    .size        (core_size),
    .store_data  (core_write_data),
    .load_word   (memory_read_data),
    .byte_enable (memory_byte_enable_map),
    .write_data  (memory_write_data),
    .read_data   (core_read_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: directed self-checking bench for rv_lsu.
`default_nettype none

module tb_rv_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] core_address;
  logic [31:0] core_write_data;
  logic        core_require;
  logic        core_write_enable;
  logic [2:0]  core_size;
  logic [31:0] core_read_data;
  logic        core_stall_signal;
  logic [31:0] memory_read_data;
  logic        memory_begin_signal;
  logic        memory_end_signal;
  logic        memory_require;
  logic        memory_write_enable;
  logic [3:0]  memory_byte_enable_map;
  logic [31:0] memory_address;
  logic [31:0] memory_write_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv_lsu dut (
    .clk                    (clk),
    .reset                  (reset),
    .core_address           (core_address),
    .core_write_data        (core_write_data),
    .core_require           (core_require),
    .core_write_enable      (core_write_enable),
    .core_size              (core_size),
    .core_read_data         (core_read_data),
    .core_stall_signal      (core_stall_signal),
    .memory_read_data       (memory_read_data),
    .memory_begin_signal    (memory_begin_signal),
    .memory_end_signal      (memory_end_signal),
    .memory_require         (memory_require),
    .memory_write_enable    (memory_write_enable),
    .memory_byte_enable_map (memory_byte_enable_map),
    .memory_address         (memory_address),
    .memory_write_data      (memory_write_data)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one cycle; inputs change and checks happen away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input logic mbegin, input logic mend);
    core_require        = req;
    core_write_enable   = we;
    core_size           = size;
    core_address        = addr;
    core_write_data     = wd;
    memory_read_data    = rd;
    memory_begin_signal = mbegin;
    memory_end_signal   = mend;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_mem_req",   {31'd0, memory_require},      32'd0);
    check("rst_mem_we",    {31'd0, memory_write_enable}, 32'd0);
    check("rst_stall",     {31'd0, core_stall_signal},   32'd0);
    check("rst_read_data", core_read_data,               32'd0);
    reset = 1'b0;

    // LW 0x100: begin in cycle 1, end in cycle 3
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
    check("lw_c0_stall",   {31'd0, core_stall_signal},   32'd1);
    check("lw_c0_req",     {31'd0, memory_require},      32'd1);
    check("lw_addr",       memory_address,               32'h100);
    check("lw_map",        {28'd0, memory_byte_enable_map}, 32'hF);
    tick();
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0);
    check("lw_c1_stall",   {31'd0, core_stall_signal},   32'd1);
    check("lw_c1_req",     {31'd0, memory_require},      32'd1);
    tick();
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
    check("lw_c2_stall",   {31'd0, core_stall_signal},   32'd1);
    check("lw_c2_req_wait",{31'd0, memory_require},      32'd0);
    tick();
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    check("lw_c3_stall",   {31'd0, core_stall_signal},   32'd0);
    check("lw_c3_req_wait",{31'd0, memory_require},      32'd0);
    check("lw_data",       core_read_data,               32'hDEADBEEF);
    tick();
    drive(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
    check("lw_done_req",   {31'd0, memory_require},      32'd0);
    tick();

    // LB / LBU at byte 3, same-cycle begin+end
    drive(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1'b1, 1'b1);
    check("lb_map",        {28'd0, memory_byte_enable_map}, 32'h8);
    check("lb_data",       core_read_data,               32'hFFFFFF80);
    check("lb_stall",      {31'd0, core_stall_signal},   32'd0);
    check("lb_addr",       memory_address,               32'h100);
    tick();
    drive(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1'b1, 1'b1);
    check("lbu_data",      core_read_data,               32'h00000080);
    drive(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h80112233, 1'b1, 1'b1);
    check("lb1_map",       {28'd0, memory_byte_enable_map}, 32'h2);
    check("lb1_data",      core_read_data,               32'h00000022);
    tick();

    // SH 0x202: upper halfword, replicated store data
    drive(1'b1, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 1'b0, 1'b0);
    check("sh_addr",       memory_address,               32'h200);
    check("sh_map",        {28'd0, memory_byte_enable_map}, 32'hC);
    check("sh_wdata",      memory_write_data,            32'hABCDABCD);
    check("sh_we",         {31'd0, memory_write_enable}, 32'd1);
    tick();
    drive(1'b1, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 1'b1, 1'b1);
    check("sh_req_state",  {31'd0, memory_require},      32'd1);
    tick();
    drive(1'b1, 1'b1, 3'b000, 32'h101, 32'h12345678, 32'h0, 1'b1, 1'b1);
    check("sb_map",        {28'd0, memory_byte_enable_map}, 32'h2);
    check("sb_wdata",      memory_write_data,            32'h78787878);
    tick();

    // LHU / LH at 0x002, begin+end same cycle
    drive(1'b1, 1'b0, 3'b101, 32'h002, 32'h0, 32'h8001FFFF, 1'b1, 1'b1);
    check("lhu_stall",     {31'd0, core_stall_signal},   32'd0);
    check("lhu_data",      core_read_data,               32'h00008001);
    tick();
    drive(1'b1, 1'b0, 3'b001, 32'h002, 32'h0, 32'h8001FFFF, 1'b1, 1'b1);
    check("lh_data",       core_read_data,               32'hFFFF8001);
    drive(1'b1, 1'b0, 3'b001, 32'h001, 32'h0, 32'h8001FFFF, 1'b1, 1'b1);
    check("lh_odd_map",    {28'd0, memory_byte_enable_map}, 32'h3);
    check("lh_odd_data",   core_read_data,               32'hFFFFFFFF);
    drive(1'b1, 1'b0, 3'b101, 32'h000, 32'h0, 32'h12347F00, 1'b1, 1'b1);
    check("lhu_low_data",  core_read_data,               32'h00007F00);
    tick();

    // Reserved size codes act as word accesses
    drive(1'b1, 1'b1, 3'b011, 32'h103, 32'hCAFEF00D, 32'h89ABCDEF, 1'b1, 1'b1);
    check("rsv011_map",    {28'd0, memory_byte_enable_map}, 32'hF);
    check("rsv011_wdata",  memory_write_data,            32'hCAFEF00D);
    check("rsv011_rdata",  core_read_data,               32'h89ABCDEF);
    drive(1'b1, 1'b0, 3'b111, 32'h101, 32'hCAFEF00D, 32'h89ABCDEF, 1'b1, 1'b1);
    check("rsv111_rdata",  core_read_data,               32'h89ABCDEF);
    check("rsv111_map",    {28'd0, memory_byte_enable_map}, 32'hF);
    tick();

    // core_require low: end ignored, no stall
    drive(1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 32'h0, 1'b0, 1'b1);
    check("idle_end_stall",{31'd0, core_stall_signal},   32'd0);
    check("idle_end_req",  {31'd0, memory_require},      32'd0);
    check("idle_we",       {31'd0, memory_write_enable}, 32'd0);
    tick();

    // Into WAIT, store blocked there; dropping core_require returns to IDLE
    drive(1'b1, 1'b1, 3'b010, 32'h300, 32'h11, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 3'b010, 32'h300, 32'h11, 32'h0, 1'b0, 1'b0);
    check("wait_req",      {31'd0, memory_require},      32'd0);
    check("wait_we",       {31'd0, memory_write_enable}, 32'd0);
    tick();
    check("wait_hold_req", {31'd0, memory_require},      32'd0);
    drive(1'b0, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 1'b0, 1'b0);
    check("drop_to_idle",  {31'd0, memory_require},      32'd1);

    // Reset while in WAIT
    drive(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b0, 1'b0);
    check("pre_rst_wait",  {31'd0, memory_require},      32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_wait_req",  {31'd0, memory_require},      32'd1);
    check("rst_wait_stall",{31'd0, core_stall_signal},   32'd1);
    tick();
    check("rst_req_state", {31'd0, memory_require},      32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
